// File: rtl/banco_registradores_param.sv
// banco_registradores_param: parameterised 2-read/1-write register bank with
// a sequential clear (one register per cycle) and registered reads.
// Optional macro BANCO_REGISTRADORES_BYPASS_EN selects write-first reads on
// a same-address read/write; without it, reads are read-first.
module banco_registradores_param #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 32,
  parameter int ZERO_FIXO    = 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            limpar,
  input  logic                            RegWrite,
  input  logic [$clog2(PROFUNDIDADE)-1:0] r1,
  input  logic [$clog2(PROFUNDIDADE)-1:0] r2,
  input  logic [$clog2(PROFUNDIDADE)-1:0] r3,
  input  logic [LARGURA-1:0]              dado_escrita,
  output logic [LARGURA-1:0]              dado_lido1,
  output logic [LARGURA-1:0]              dado_lido2,
  output logic                            pronto
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW-1:0] ULTIMO = AW'(PROFUNDIDADE - 1);
`ifdef BANCO_REGISTRADORES_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {LIMPANDO, OCIOSO} estado_t;

  estado_t            r_estado, w_prox_estado;
  logic [AW-1:0]      r_contador, w_prox_contador;
  logic [LARGURA-1:0] r_banco [PROFUNDIDADE];
  logic [LARGURA-1:0] r_lido1, r_lido2;
  logic [LARGURA-1:0] w_leitura1, w_leitura2;
  logic               w_escreve;
  logic               w_zero1, w_zero2;

  // Next state: clear walks the bank once, limpar (re)starts it from index 0
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_contador = r_contador;
    if (r_estado == LIMPANDO) begin
      w_prox_contador = limpar ? '0 : r_contador + 1'b1;
      w_prox_estado   = (!limpar && r_contador == ULTIMO) ? OCIOSO : LIMPANDO;
    end else if (limpar) begin
      w_prox_estado   = LIMPANDO;
      w_prox_contador = '0;
    end
  end

  // Write qualification and read data selection (hardwired zero, optional bypass)
  always_comb begin
    w_escreve  = (r_estado == OCIOSO) && !limpar && RegWrite &&
                 !(ZERO_FIXO != 0 && r3 == '0);
    w_zero1    = (ZERO_FIXO != 0) && (r1 == '0);
    w_zero2    = (ZERO_FIXO != 0) && (r2 == '0);
    w_leitura1 = w_zero1 ? '0 :
                 (BYPASS && w_escreve && r3 == r1) ? dado_escrita : r_banco[r1];
    w_leitura2 = w_zero2 ? '0 :
                 (BYPASS && w_escreve && r3 == r2) ? dado_escrita : r_banco[r2];
  end

  // FSM state and clear index; reset restarts the clear sequence
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= LIMPANDO;
      r_contador <= '0;
    end else begin
      r_estado   <= w_prox_estado;
      r_contador <= w_prox_contador;
    end
  end

  // Storage array is never reset; the clear sequence zeroes it instead
  always_ff @(posedge clock) begin
    if (r_estado == LIMPANDO)
      r_banco[r_contador] <= '0;
    else if (w_escreve)
      r_banco[r3] <= dado_escrita;
  end

  // Registered read ports, held at zero while clearing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lido1 <= '0;
      r_lido2 <= '0;
    end else if (r_estado == LIMPANDO) begin
      r_lido1 <= '0;
      r_lido2 <= '0;
    end else begin
      r_lido1 <= w_leitura1;
      r_lido2 <= w_leitura2;
    end
  end

  assign pronto     = (r_estado == OCIOSO);
  assign dado_lido1 = pronto ? r_lido1 : '0;
  assign dado_lido2 = pronto ? r_lido2 : '0;

endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: randomized + directed checks of the register
// bank against a behavioural array model with a clear-cycle countdown.
module tb_banco_registradores_param;

  localparam int P = 32;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        limpar = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  r1 = '0, r2 = '0, r3 = '0;
  logic [31:0] dado_escrita = '0;
  logic [31:0] dado_lido1, dado_lido2;
  logic        pronto;

  int n_checks = 0;
  int n_fails = 0;

  logic [31:0] m_mem [P];
  int          m_falta = P;
  int          m_idx = 0;
  logic [31:0] m_lido1 = '0, m_lido2 = '0;

  banco_registradores_param dut (
    .clock(clock), .reset_n(reset_n), .limpar(limpar), .RegWrite(RegWrite),
    .r1(r1), .r2(r2), .r3(r3), .dado_escrita(dado_escrita),
    .dado_lido1(dado_lido1), .dado_lido2(dado_lido2), .pronto(pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_le(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYPASS && RegWrite && !limpar && a == r3) return dado_escrita;
    return m_mem[a];
  endfunction

  task automatic step();
    @(posedge clock);
    if (m_falta > 0) begin
      m_mem[m_idx] = '0;
      m_lido1 = '0;
      m_lido2 = '0;
      if (limpar) begin m_idx = 0; m_falta = P; end
      else begin m_idx++; m_falta--; end
    end else begin
      m_lido1 = m_le(r1);
      m_lido2 = m_le(r2);
      if (limpar) begin m_idx = 0; m_falta = P; end
      else if (RegWrite && r3 != 0) m_mem[r3] = dado_escrita;
    end
    #1;
    chk("pronto", 32'(pronto), 32'(m_falta == 0));
    chk("lido1", dado_lido1, m_falta == 0 ? m_lido1 : 32'h0);
    chk("lido2", dado_lido2, m_falta == 0 ? m_lido2 : 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_falta = P;
    m_idx = 0;
    chk("rst_pronto", 32'(pronto), 32'h0);
    chk("rst_lido1", dado_lido1, 32'h0);
    chk("rst_lido2", dado_lido2, 32'h0);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_pronto(output int n);
    n = 0;
    while (pronto !== 1'b1 && n < 100) begin
      RegWrite = 1'($urandom_range(0, 1));
      r3 = 5'($urandom_range(0, 31));
      dado_escrita = $urandom;
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      step();
      n++;
    end
  endtask

  task automatic read_all();
    RegWrite = 1'b0;
    limpar = 1'b0;
    for (int i = 0; i < P; i++) begin
      r1 = 5'(i);
      r2 = 5'(P - 1 - i);
      step();
      chk("zero_rd", dado_lido1 | dado_lido2, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < P; i++) m_mem[i] = '0;
    #2;
    do_reset();
    wait_pronto(n);
    chk("clear_cycles_reset", 32'(n), 32'd32);
    read_all();

    RegWrite = 1'b1; r3 = 5'd5; dado_escrita = 32'hDEADBEEF;
    step();
    RegWrite = 1'b0; r1 = 5'd5; r2 = 5'd5;
    step();
    chk("deadbeef1", dado_lido1, 32'hDEADBEEF);
    chk("deadbeef2", dado_lido2, 32'hDEADBEEF);

    RegWrite = 1'b1; r3 = 5'd0; dado_escrita = 32'hFFFFFFFF;
    step();
    RegWrite = 1'b0; r1 = 5'd0; r2 = 5'd0;
    step();
    chk("zero_fixo", dado_lido1 | dado_lido2, 32'h0);

    RegWrite = 1'b1; r3 = 5'd7; dado_escrita = 32'h12345678; r1 = 5'd7; r2 = 5'd7;
    step();
    chk("rdw_same", dado_lido1, BYPASS ? 32'h12345678 : 32'h0);
    RegWrite = 1'b0;
    step();
    chk("rdw_after", dado_lido1, 32'h12345678);

    for (int i = 1; i < P; i++) begin
      RegWrite = 1'b1; r3 = 5'(i); dado_escrita = $urandom | 32'h1;
      step();
    end
    RegWrite = 1'b1; limpar = 1'b1; r3 = 5'd3; dado_escrita = 32'hA5A5A5A5;
    step();
    limpar = 1'b0;
    wait_pronto(n);
    chk("clear_cycles_limpar", 32'(n), 32'd32);
    read_all();

    limpar = 1'b1;
    step();
    limpar = 1'b0;
    for (int i = 0; i < 5; i++) step();
    limpar = 1'b1;
    step();
    limpar = 1'b0;
    wait_pronto(n);
    chk("clear_restart", 32'(n), 32'd32);

    limpar = 1'b1;
    step();
    limpar = 1'b0;
    for (int i = 0; i < 10; i++) step();
    do_reset();
    wait_pronto(n);
    chk("clear_after_midreset", 32'(n), 32'd32);
    read_all();

    for (int k = 0; k < 3000; k++) begin
      limpar = ($urandom_range(0, 59) == 0);
      RegWrite = 1'($urandom_range(0, 1));
      dado_escrita = $urandom;
      r1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r3 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      step();
      if ($urandom_range(0, 499) == 0) begin
        limpar = 1'b0;
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
